// File: rtl/mdu_pkg.sv
// Shared constants for the EX-stage ALU controller and its multiply/divide unit.
//
// Contents:
//   ALUOp class constants, ALU and MDU funct codes, ALUCtl codes,
//   and the 2-bit MDU sequencer state encoding.
package mdu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide engine with the architectural HI/LO registers.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; HI/LO writable through wr_hi/wr_lo
//   MUL   | one shift-add step per cycle, counter counts down
//   DIV   | one restoring shift-subtract step per cycle, counter counts down
//   FIX   | apply result signs, write HI/LO, return to IDLE
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op[1:0]  begin an operation: op = {div, unsigned}
//   a, b            operands (a also carries mthi/mtlo data)
//   wr_hi, wr_lo    direct HI/LO write from a
//   busy            operation in progress
//   hi, lo          HI/LO register contents
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q, neg_r, is_div;

  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_use, b_use;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic               sub_ok;

  // Division by zero keeps the raw dividend and no sign flags, so the
  // plain algorithm leaves quotient = all ones and remainder = dividend.
  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    div_zero = op[1] & (b == '0);
    a_use    = (a_neg & ~div_zero) ? -a : a;
    b_use    = b_neg ? -b : b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, b_reg};
    // A zero divisor always "fits", forcing every quotient bit to one.
    sub_ok   = ~div_diff[WIDTH] | (b_reg == '0);
    div_next = sub_ok ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                      : {div_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
    prod_fix = neg_q ? -acc : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = op[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:  if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      b_reg  <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_hi) hi <= a;
          if (wr_lo) lo <= a;
          if (start) begin
            cnt    <= CNT_W'(WIDTH);
            is_div <= op[1];
            neg_q  <= ~div_zero & (a_neg ^ b_neg);
            neg_r  <= ~div_zero & a_neg;
            if (op[1]) begin
              b_reg <= b_use;
              acc   <= {{WIDTH{1'b0}}, a_use};
            end else begin
              b_reg <= a_use;
              acc   <= {{WIDTH{1'b0}}, b_use};
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (is_div) begin
            lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU controller: ALUOp/funct decode to ALUCtl, MDU issue/stall
// control and mfhi/mflo result selection.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ALUOp, FuncCode     main-decoder class and R-type funct
//   issue               valid instruction in EX this cycle
//   SrcA, SrcB          rs / rt operands
//   ALUCtl              ALU control code
//   MduResult           HI (mfhi) or LO (mflo), else 0
//   ResultSel           EX result taken from MduResult
//   Busy, Stall         MDU in progress / hold IF-ID-EX
module alu_mdu_controller
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic             issue,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [3:0]       ALUCtl,
  output logic [WIDTH-1:0] MduResult,
  output logic             ResultSel,
  output logic             Busy,
  output logic             Stall
);

  logic rtype, is_mdu, accept, is_mfhi, is_mflo, is_arith;
  logic [WIDTH-1:0] hi, lo;

  always_comb begin
    ALUCtl = CTL_AND;
    case (ALUOp)
      ALUOP_ADD: ALUCtl = CTL_ADD;
      ALUOP_SUB: ALUCtl = CTL_SUB;
      ALUOP_RTYPE: begin
        case (FuncCode)
          F_ADD, F_ADDU: ALUCtl = CTL_ADD;
          F_SUB, F_SUBU: ALUCtl = CTL_SUB;
          F_AND:         ALUCtl = CTL_AND;
          F_OR:          ALUCtl = CTL_OR;
          F_XOR:         ALUCtl = CTL_XOR;
          F_NOR:         ALUCtl = CTL_NOR;
          F_SLT:         ALUCtl = CTL_SLT;
          F_SLTU:        ALUCtl = CTL_SLTU;
          default:       ALUCtl = CTL_AND;
        endcase
      end
      default: ALUCtl = CTL_AND;
    endcase
  end

  // MDU functs occupy 0100xx and 0110xx.
  assign rtype    = (ALUOp == ALUOP_RTYPE);
  assign is_mdu   = rtype & (FuncCode[5:4] == 2'b01) & (FuncCode[2] == 1'b0);
  assign is_arith = is_mdu & FuncCode[3];
  assign is_mfhi  = rtype & (FuncCode == F_MFHI);
  assign is_mflo  = rtype & (FuncCode == F_MFLO);

  assign Stall  = issue & is_mdu & Busy;
  assign accept = issue & is_mdu & ~Busy;

  assign ResultSel = issue & (is_mfhi | is_mflo);
  assign MduResult = (issue & is_mfhi) ? hi :
                     (issue & is_mflo) ? lo : '0;

  mdu_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (accept & is_arith),
    .op    (FuncCode[1:0]),
    .a     (SrcA),
    .b     (SrcB),
    .wr_hi (accept & rtype & (FuncCode == F_MTHI)),
    .wr_lo (accept & rtype & (FuncCode == F_MTLO)),
    .busy  (Busy),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_mdu_controller.sv
module tb_alu_mdu_controller;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   ALUOp = 2'b00;
  logic [5:0]   FuncCode = 6'd0;
  logic         issue = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [3:0]   ALUCtl;
  logic [W-1:0] MduResult;
  logic         ResultSel, Busy, Stall;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  alu_mdu_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .FuncCode(FuncCode), .issue(issue),
    .SrcA(SrcA), .SrcB(SrcB), .ALUCtl(ALUCtl), .MduResult(MduResult),
    .ResultSel(ResultSel), .Busy(Busy), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic iss,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = op; FuncCode = f; issue = iss; SrcA = a; SrcB = b;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 6'd0, 1'b0, '0, '0);
  endtask

  task automatic issue_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(2'b10, f, 1'b1, a, b);
    step();
    idle();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 200) begin step(); n++; end
    if (n >= 200) bound_fail(tag);
  endtask

  // Issue mfhi/mflo, ride out any stall, compare against the scoreboard.
  task automatic read_reg(input logic [5:0] f, input string tag);
    int n = 0;
    drive(2'b10, f, 1'b1, '0, '0);
    while (Stall && n < 200) begin step(); n++; end
    if (n >= 200) bound_fail(tag);
    chk({tag, "_sel"}, W'(ResultSel), W'(1));
    if (exp_q.size() == 0) bound_fail({tag, "_empty_queue"});
    else chk(tag, MduResult, exp_q.pop_front());
    step();
    idle();
  endtask

  task automatic alu_case(input logic [1:0] op, input logic [5:0] f, input logic [3:0] exp,
                          input string tag);
    drive(op, f, 1'b0, '0, '0);
    chk(tag, W'(ALUCtl), W'(exp));
  endtask

  initial begin
    int n;

    // Reset state
    #2;
    chk("rst_busy", W'(Busy), '0);
    chk("rst_stall", W'(Stall), '0);
    chk("rst_sel", W'(ResultSel), '0);
    chk("rst_result", MduResult, '0);
    step(); step();
    rst = 1'b0;
    step();

    // ALU decode
    alu_case(2'b10, 6'b100111, 4'b1100, "alu_nor");
    alu_case(2'b10, 6'b101011, 4'b1000, "alu_sltu");
    alu_case(2'b01, 6'b101101, 4'b0110, "alu_op01");
    alu_case(2'b10, 6'b111111, 4'b0000, "alu_unknown");
    alu_case(2'b10, 6'b100001, 4'b0010, "alu_addu");
    alu_case(2'b10, 6'b100010, 4'b0110, "alu_sub");
    alu_case(2'b10, 6'b100101, 4'b0001, "alu_or");
    alu_case(2'b10, 6'b100110, 4'b0011, "alu_xor");
    alu_case(2'b10, 6'b101010, 4'b0111, "alu_slt");
    alu_case(2'b00, 6'b000000, 4'b0010, "alu_op00");
    alu_case(2'b11, 6'b100101, 4'b0000, "alu_op11");
    idle();

    // multu 0xFFFFFFFF * 2, Busy length
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'h0000_0001);
    issue_op(6'b011001, 32'hFFFF_FFFF, 32'h0000_0002);
    n = 0;
    while (Busy && n < 100) begin n++; step(); end
    chk("multu_busy_cycles", W'(n), W'(W + 1));
    read_reg(6'b010010, "multu_lo");
    read_reg(6'b010000, "multu_hi");

    // mult -3 * 5; add during Busy; mflo issued one cycle later stalls WIDTH cycles
    exp_q.push_back(32'hFFFF_FFF1);
    exp_q.push_back(32'hFFFF_FFFF);
    issue_op(6'b011000, 32'hFFFF_FFFD, 32'h0000_0005);
    drive(2'b10, 6'b100000, 1'b1, 32'd1, 32'd2);
    chk("add_busy_stall", W'(Stall), '0);
    chk("add_busy_aluctl", W'(ALUCtl), W'(4'b0010));
    step();
    drive(2'b10, 6'b010010, 1'b1, '0, '0);
    n = 0;
    while (Stall && n < 100) begin n++; step(); end
    chk("mflo_stall_cycles", W'(n), W'(W));
    chk("mult_lo_sel", W'(ResultSel), W'(1));
    chk("mult_lo", MduResult, exp_q.pop_front());
    step();
    idle();
    read_reg(6'b010000, "mult_hi");

    // div -7 / 2
    exp_q.push_back(32'hFFFF_FFFD);
    exp_q.push_back(32'hFFFF_FFFF);
    issue_op(6'b011010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle("div_wait");
    read_reg(6'b010010, "div_lo");
    read_reg(6'b010000, "div_hi");

    // divu 7 / 0
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0007);
    issue_op(6'b011011, 32'h0000_0007, 32'h0000_0000);
    wait_idle("divu0_wait");
    read_reg(6'b010010, "divu0_lo");
    read_reg(6'b010000, "divu0_hi");

    // signed MIN / -1
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h0000_0000);
    issue_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("minov_wait");
    read_reg(6'b010010, "minov_lo");
    read_reg(6'b010000, "minov_hi");

    // mthi / mtlo: no Busy, read back next cycle without stall
    exp_q.push_back(32'h0000_1234);
    issue_op(6'b010001, 32'h0000_1234, 32'h0);
    chk("mthi_busy", W'(Busy), '0);
    drive(2'b10, 6'b010000, 1'b1, '0, '0);
    chk("mfhi_no_stall", W'(Stall), '0);
    read_reg(6'b010000, "mthi_read");
    exp_q.push_back(32'h0000_5678);
    issue_op(6'b010011, 32'h0000_5678, 32'h0);
    read_reg(6'b010010, "mtlo_read");

    // mthi during Busy is held off
    issue_op(6'b011011, 32'd100, 32'd7);
    drive(2'b10, 6'b010001, 1'b1, 32'hDEAD_BEEF, '0);
    chk("mthi_busy_stall", W'(Stall), W'(1));
    idle();

    // Asynchronous reset in cycle 10 of a division
    repeat (8) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", W'(Busy), '0);
    chk("arst_sel_idle", W'(ResultSel), '0);
    drive(2'b10, 6'b010000, 1'b1, '0, '0);
    chk("arst_hi", MduResult, '0);
    chk("arst_stall", W'(Stall), '0);
    drive(2'b10, 6'b010010, 1'b1, '0, '0);
    chk("arst_lo", MduResult, '0);
    idle();
    step();
    rst = 1'b0;
    step();
    drive(2'b10, 6'b010010, 1'b1, '0, '0);
    chk("post_rst_mflo_stall", W'(Stall), '0);
    exp_q.push_back(32'h0);
    read_reg(6'b010010, "post_rst_mflo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
